branch_predict_ctrl: RTL
========================

// Module: branch_predict_ctrl
// PURPOSE
//  Branch prediction and misprediction-recovery controller around the EX-stage
//  branch comparator. Predicts conditional branches at IF from a table of 2-bit
//  saturating counters, checks each resolved branch against the comparator
//  result, trains the table, and drives a one-cycle redirect/flush to IF/ID/EX.
//  Also keeps branch and mispredict statistics counters.
// PARAMETERS
//  BHT_ENTRIES  64     counter-table depth; power of 2, >= 2; IDX_W = $clog2(BHT_ENTRIES)
//  CTR_INIT     2'b01  reset value of every counter (weakly not-taken)
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  rst             in   1   synchronous reset, active-high
//  if_pc           in   32  fetch-stage PC to predict
//  if_pred_taken   out  1   prediction for if_pc (combinational table read)
//  ex_valid        in   1   EX holds a valid instruction
//  ex_comp_op      in   comp_op_t  comparator op (control_types_pkg); BR_NOP = not a branch
//  ex_pc           in   32  PC of the EX instruction
//  ex_target       in   32  taken target of the EX branch
//  ex_pred_taken   in   1   prediction carried down the pipe with the branch
//  br_result       in   1   branch comparator outcome (1 = taken)
//  stall           in   1   pipeline stall; EX does not advance this cycle
//  redirect_valid  out  1   load redirect_pc into PC; registered
//  redirect_pc     out  32  corrected fetch address; registered
//  flush           out  1   squash IF/ID and ID/EX contents; registered
//  branch_count    out  32  resolved conditional branches, saturating
//  mispred_count   out  32  mispredicted branches, saturating
// BEHAVIOUR
//  Reset: all counters = CTR_INIT, FSM = RUN, redirect_valid = 0, flush = 0,
//   redirect_pc = 0, branch_count = mispred_count = 0. Any in-flight redirect dropped.
//  Index: idx = pc[IDX_W+1:2] for both lookup and update; pc[1:0] ignored.
//  Lookup: if_pred_taken = table[idx(if_pc)][1]. Same-cycle update to same idx is
//   not visible until the next cycle (read-before-write).
//  Resolve: fires when FSM==RUN && ex_valid && !stall && ex_comp_op != BR_NOP.
//   - table[idx(ex_pc)] += 1 if br_result (sat at 3), -= 1 otherwise (sat at 0).
//   - branch_count += 1 (sat 32'hFFFF_FFFF).
//   - mispredict = (br_result != ex_pred_taken): mispred_count += 1 (sat),
//     next cycle redirect_valid = flush = 1, FSM -> REDIRECT.
//   - redirect_pc = br_result ? ex_target : ex_pc + 32'd4 (mod 2^32 wrap).
//  Stall: with stall=1 nothing resolves, no table/counter update, outputs hold;
//   branch resolves in the first cycle stall=0 (exactly once).
//  FSM: RUN -> REDIRECT on mispredict; REDIRECT -> RUN unconditionally after one
//   cycle. In REDIRECT, redirect_valid = flush = 1 for exactly that cycle; EX
//   inputs are wrong-path and ignored (no resolve, no training, no counting),
//   even if stall=1. Back-to-back mispredicts therefore need >= 1 intervening cycle.
//  Correct prediction: no redirect, no flush, FSM stays RUN.
//  Latency: mispredict at EX in cycle N -> redirect/flush high in cycle N+1.
//  redirect_pc holds its last value when redirect_valid = 0.
// TESTING
//  1 Reset: rst 1 cycle -> if_pred_taken=0 for any if_pc, counts 0, flush=0.
//  2 BR_LT, ex_pc=0x100, target=0x80, br_result=1, pred=0 -> next cycle
//    redirect_valid=1, redirect_pc=0x80, flush=1, mispred_count=1; cycle after: all 0.
//  3 Train: 2 taken resolves at ex_pc=0x40 -> if_pc=0x40 predicts 1; 3 further
//    not-taken -> predicts 0; counter never wraps past 0 or 3.
//  4 BR_GEU not-taken, pred=1, ex_pc=0xFFFF_FFFC -> redirect_pc=0x0000_0000.
//  5 Mispredict with stall=1 for 3 cycles -> no redirect, counts unchanged;
//    stall=0 -> single redirect, branch_count +1 only once.
//  6 Mispredict then valid mispredicting branch in REDIRECT cycle -> ignored,
//    one redirect pulse; rst asserted during REDIRECT -> flush=0 next cycle.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// Branch predictor (2-bit saturating counter table) with misprediction recovery
// and branch/mispredict statistics around the EX-stage comparator.
package control_types_pkg;
    typedef enum logic [2:0] {
        BR_NOP,
        BR_EQ,
        BR_NE,
        BR_LT,
        BR_GE,
        BR_LTU,
        BR_GEU
    } comp_op_t;
endpackage

module branch_predict_ctrl
    import control_types_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  comp_op_t    ex_comp_op,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic        br_result,
    input  logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] branch_count,
    output logic [31:0] mispred_count
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic {
        ST_RUN,
        ST_REDIRECT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_bht [BHT_ENTRIES];
    logic              r_redirect_valid;
    logic              r_flush;
    logic [31:0]       r_redirect_pc;
    logic [31:0]       r_branch_count;
    logic [31:0]       r_mispred_count;

    logic [IDX_W-1:0]  w_if_idx;
    logic [IDX_W-1:0]  w_ex_idx;
    logic [1:0]        w_ctr_cur;
    logic [1:0]        w_ctr_nxt;
    logic              w_resolve;
    logic              w_mispred;
    logic              w_unused;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_unused = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Read-before-write: an update in this cycle shows up only after the edge.
    assign if_pred_taken = r_bht[w_if_idx][1];

    // Wrong-path instructions during REDIRECT never resolve.
    assign w_resolve = (r_state == ST_RUN) && ex_valid && !stall && (ex_comp_op != BR_NOP);
    assign w_mispred = w_resolve && (br_result != ex_pred_taken);

    assign w_ctr_cur = r_bht[w_ex_idx];

    always_comb begin
        w_ctr_nxt = w_ctr_cur;
        if (br_result) begin
            if (w_ctr_cur != 2'b11) w_ctr_nxt = w_ctr_cur + 2'b01;
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_nxt = w_ctr_cur - 2'b01;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:      if (w_mispred) w_state_nxt = ST_REDIRECT;
            ST_REDIRECT: w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= CTR_INIT;
            end
        end else if (w_resolve) begin
            r_bht[w_ex_idx] <= w_ctr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_flush          <= 1'b0;
            r_redirect_pc    <= '0;
            r_branch_count   <= '0;
            r_mispred_count  <= '0;
        end else begin
            r_redirect_valid <= w_mispred;
            r_flush          <= w_mispred;
            if (w_mispred) begin
                r_redirect_pc <= br_result ? ex_target : (ex_pc + 32'd4);
            end
            if (w_resolve && (r_branch_count != '1)) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (w_mispred && (r_mispred_count != '1)) begin
                r_mispred_count <= r_mispred_count + 32'd1;
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign flush          = r_flush;
    assign redirect_pc    = r_redirect_pc;
    assign branch_count   = r_branch_count;
    assign mispred_count  = r_mispred_count;

endmodule
